// File: rtl/pe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pe_pkg : shared PE defaults and drain FSM state encoding (rev 1.0)    |
// +-----------------------------------------------------------------------+
package pe_pkg;

  localparam int NUM_BUF_DEF = 10;
  localparam int ACC_W_DEF   = 36;
  localparam int OUT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } pe_state_e;

  // Index width that stays legal for a single-entry buffer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_requant.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pe_requant : ReLU, arithmetic right shift, signed saturation (rev 1.0)|
// +-----------------------------------------------------------------------+
module pe_requant #(
  parameter int ACC_W   = 36,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int RELU_EN = 1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] q
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    q       = shifted[OUT_W-1:0];
    if ((RELU_EN != 0) && acc[ACC_W-1]) begin
      q = '0;
    end else if (shifted > SAT_MAX) begin
      q = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      q = SAT_MIN[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_drain.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pe_drain : snapshots the reducer buffer and streams requantised       |
// |            entries over a valid/ready handshake (rev 1.0)             |
// +-----------------------------------------------------------------------+
module pe_drain
  import pe_pkg::*;
#(
  parameter int NUM_BUF  = NUM_BUF_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int SHIFT    = 0,
  parameter int RELU_EN  = 1,
  localparam int IDX_W   = idx_w(NUM_BUF)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_finish,
  input  logic [NUM_BUF*ACC_W-1:0] i_buf,
  output logic [OUT_W-1:0]         o_data,
  output logic [IDX_W-1:0]         o_idx,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overrun
);

  pe_state_e        state;
  pe_state_e        state_nxt;
  logic [ACC_W-1:0] snap [NUM_BUF];
  logic [IDX_W-1:0] idx;
  logic             overrun;
  logic [ACC_W-1:0] cur;
  logic             xfer;
  logic             last;
  logic             capture;

  assign xfer    = (state == ST_SEND) && i_ready;
  assign last    = (idx == IDX_W'(NUM_BUF - 1));
  assign capture = (state != ST_SEND) && i_finish;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_finish) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (xfer && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = i_finish ? ST_SEND : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A finish arriving mid-pass leaves the snapshot untouched and is only flagged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_BUF; k++) snap[k] <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= (state == ST_SEND) && i_finish;
      if (capture) begin
        for (int k = 0; k < NUM_BUF; k++) snap[k] <= i_buf[k*ACC_W +: ACC_W];
        idx <= '0;
      end else if (xfer && !last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      if (idx == IDX_W'(k)) cur = snap[k];
    end
  end

  pe_requant #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT   (SHIFT),
    .RELU_EN (RELU_EN)
  ) u_requant (
    .acc (cur),
    .q   (o_data)
  );

  assign o_idx     = idx;
  assign o_overrun = overrun;

endmodule
`default_nettype wire

// File: tb/tb_pe_drain.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pe_drain : randomised bench for pe_drain against a pass-level model|
// +-----------------------------------------------------------------------+
module tb_pe_drain;

  localparam int NB = 10;
  localparam int AW = 36;
  localparam int OW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fin = 1'b0;
  logic             rdy = 1'b0;
  logic [NB*AW-1:0] bufv = '0;

  logic [OW-1:0] data, data_raw, data_sh;
  logic [3:0]    idx, idx_raw, idx_sh;
  logic          valid, busy, done, ovr;
  logic          valid_raw, busy_raw, done_raw, ovr_raw;
  logic          valid_sh, busy_sh, done_sh, ovr_sh;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_drain dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_finish(fin), .i_buf(bufv),
    .o_data(data), .o_idx(idx), .o_valid(valid), .i_ready(rdy),
    .o_busy(busy), .o_done(done), .o_overrun(ovr)
  );

  pe_drain #(.SHIFT(0), .RELU_EN(0)) dut_raw (
    .i_clk(clk), .i_rst_n(rst_n), .i_finish(fin), .i_buf(bufv),
    .o_data(data_raw), .o_idx(idx_raw), .o_valid(valid_raw), .i_ready(rdy),
    .o_busy(busy_raw), .o_done(done_raw), .o_overrun(ovr_raw)
  );

  pe_drain #(.SHIFT(4), .RELU_EN(1)) dut_sh (
    .i_clk(clk), .i_rst_n(rst_n), .i_finish(fin), .i_buf(bufv),
    .o_data(data_sh), .o_idx(idx_sh), .o_valid(valid_sh), .i_ready(rdy),
    .o_busy(busy_sh), .o_done(done_sh), .o_overrun(ovr_sh)
  );

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint f_ref(input longint x, input bit relu, input int sh);
    longint y;
    if (relu && x < 0) return 0;
    y = x >>> sh;
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return y;
  endfunction

  // Pass-level reference: a pass owns a frozen copy of the buffer and walks it.
  bit     m_active, m_done, m_ovr;
  int     m_idx;
  longint m_snap [NB];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_ovr = 0; m_idx = 0;
      for (int k = 0; k < NB; k++) m_snap[k] = 0;
    end else begin
      m_done = 0;
      m_ovr  = 0;
      if (m_active) begin
        if (fin) m_ovr = 1;
        if (rdy) begin
          if (m_idx == NB - 1) begin
            m_active = 0;
            m_done   = 1;
          end else begin
            m_idx++;
          end
        end
      end else if (fin) begin
        for (int k = 0; k < NB; k++) m_snap[k] = longint'($signed(bufv[k*AW +: AW]));
        m_idx    = 0;
        m_active = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check_val("rst_valid", valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_overrun", ovr, 0);
      check_val("rst_data", $signed(data), 0);
      check_val("rst_idx", idx, 0);
    end else begin
      check_val("valid", valid, m_active);
      check_val("busy", busy, m_active);
      check_val("done", done, m_done);
      check_val("overrun", ovr, m_ovr);
      if (m_active) begin
        check_val("idx", idx, m_idx);
        check_val("data", $signed(data), f_ref(m_snap[m_idx], 1, 0));
        check_val("data_raw", $signed(data_raw), f_ref(m_snap[m_idx], 0, 0));
        check_val("data_sh", $signed(data_sh), f_ref(m_snap[m_idx], 1, 4));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int k, input longint v);
    bufv[k*AW +: AW] = v[AW-1:0];
  endtask

  function automatic longint rand_val();
    longint v;
    case ($urandom_range(0, 3))
      0: v = longint'($urandom_range(0, 2000));
      1: v = -longint'($urandom_range(0, 2000));
      2: v = longint'($urandom_range(32768 * 15, 32768 * 17)) - 32768 * 16;
      default: begin
        v = {$urandom, $urandom};
        v = v >>> 28;
      end
    endcase
    return v;
  endfunction

  task automatic rand_buf();
    for (int k = 0; k < NB; k++) set_entry(k, rand_val());
  endtask

  task automatic pulse_finish();
    fin = 1'b1;
    tick();
    fin = 1'b0;
  endtask

  task automatic run(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((c % 4) == 0) || ((c % 4) == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      tick();
    end
  endtask

  task automatic wait_idx(input int target);
    for (int i = 0; i < 20 && !(m_active && m_idx == target); i++) tick();
    check_val("idx_reached", idx, target);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reference accumulation example.
    bufv = '0;
    set_entry(0, 45); set_entry(1, 32); set_entry(2, 17 + 20 + 10); set_entry(3, 6);
    rdy = 1'b1;
    pulse_finish();
    run(14, 0);

    // Saturation, ReLU and shift corners.
    rand_buf();
    set_entry(0, 64'sd1 <<< 20); set_entry(1, -5);
    set_entry(2, 32767); set_entry(3, -(64'sd1 <<< 20));
    pulse_finish();
    run(14, 0);

    // Backpressure pattern.
    rand_buf();
    pulse_finish();
    run(32, 1);

    // Overrun mid-pass, then back-to-back pass from the DONE cycle.
    rand_buf();
    rdy = 1'b1;
    pulse_finish();
    wait_idx(3);
    rand_buf();
    pulse_finish();
    for (int i = 0; i < 20 && !m_done; i++) tick();
    check_val("done_reached", done, 1);
    rand_buf();
    pulse_finish();
    run(14, 0);

    // Reset mid-pass aborts without a done pulse.
    rand_buf();
    pulse_finish();
    wait_idx(5);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    run(15, 0);
    rand_buf();
    pulse_finish();
    run(14, 0);

    // Random passes with random backpressure and stray finish pulses.
    repeat (25) begin
      rand_buf();
      pulse_finish();
      for (int c = 0; c < 40; c++) begin
        rdy = ($urandom_range(0, 3) != 0);
        fin = ($urandom_range(0, 19) == 0);
        if (fin) rand_buf();
        tick();
      end
      fin = 1'b0;
      run(12, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
